// File: rtl/l2_line_fill_ctrl_if.sv
// ---------------------------------------------------------------------------
// l2_line_fill_ctrl_if
// Memory-side beat bus between the L2 line-fill sequencer and main memory.
//   mem_addrstb  request strobe, held high until acknowledged (master -> slave)
//   mem_we       1 = write beat, 0 = read beat               (master -> slave)
//   mem_addr     beat byte address                           (master -> slave)
//   mem_wdata    write data                                  (master -> slave)
//   mem_rdata    read data, valid while mem_stb = 1          (slave -> master)
//   mem_stb      one-cycle acknowledge                       (slave -> master)
// ---------------------------------------------------------------------------
interface l2_line_fill_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              mem_addrstb;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_stb;

   modport master (
      output mem_addrstb, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_stb
   );

   modport slave (
      input  mem_addrstb, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_stb
   );
endinterface

// File: rtl/l2_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// l2_line_fill_ctrl
// Miss-service sequencer between the L2 cache and main memory. On req it
// optionally writes back the dirty victim line beat by beat, then reads the
// missing line beat by beat and writes each beat into the L2 array.
//   clk, reset            clock, synchronous active-high reset
//   req, req_addr         start miss service (sampled in IDLE), miss address
//   wb_en, wb_addr        victim dirty flag and victim line address
//   busy, done            transaction in progress, one-cycle completion pulse
//   wb_rd_idx/wb_rd_data  victim beat read port of the L2 array
//   fill_we/idx/data      fill beat write port of the L2 array
//   mem                   memory beat bus (master side)
//   wb_count, fill_count  saturating counts of completed lines
// COUNT_INIT is the counters' reset value; it exists so a bench can start the
// counters near saturation. Leave it at 0 in real use.
// ---------------------------------------------------------------------------
module l2_line_fill_ctrl #(
   parameter int          ADDR_W     = 32,
   parameter int          DATA_W     = 64,
   parameter int          LINE_BEATS = 4,
   parameter logic [15:0] COUNT_INIT = 16'h0000,
   localparam int         IW         = $clog2(LINE_BEATS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic              busy,
   output logic              done,
   output logic [IW-1:0]     wb_rd_idx,
   input  logic [DATA_W-1:0] wb_rd_data,
   output logic              fill_we,
   output logic [IW-1:0]     fill_idx,
   output logic [DATA_W-1:0] fill_data,
   l2_line_fill_ctrl_if.master mem,
   output logic [15:0]       wb_count,
   output logic [15:0]       fill_count
);

   // Byte offset bits inside one line (8 bytes per beat).
   localparam int          OFF_W = $clog2(LINE_BEATS * 8);
   localparam logic [IW-1:0] LAST = IW'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, WB_REQ, WB_GAP, FILL_REQ, FILL_GAP, DONE
   } state_t;

   state_t            state;
   logic [IW-1:0]     beat;
   logic [ADDR_W-1:0] wb_base;
   logic [ADDR_W-1:0] fill_base;

   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF_W], OFF_W'(0)};
   endfunction

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IW-1:0]     b);
      return base + ADDR_W'({b, 3'b000});
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // The victim beat is read combinationally by the array and forwarded as
   // write data; gating on mem_we keeps the bus at zero outside write beats.
   assign wb_rd_idx     = beat;
   assign mem.mem_wdata = mem.mem_we ? wb_rd_data : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         beat            <= '0;
         wb_base         <= '0;
         fill_base       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         fill_we         <= 1'b0;
         fill_idx        <= '0;
         fill_data       <= '0;
         mem.mem_addrstb <= 1'b0;
         mem.mem_we      <= 1'b0;
         mem.mem_addr    <= '0;
         wb_count        <= COUNT_INIT;
         fill_count      <= COUNT_INIT;
      end else begin
         // NOTE: fill_we is a pulse: defaulted low each cycle and raised only
         // on the acknowledge edge of a fill read.
         fill_we <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  wb_base         <= line_base(wb_addr);
                  fill_base       <= line_base(req_addr);
                  beat            <= '0;
                  busy            <= 1'b1;
                  mem.mem_addrstb <= 1'b1;
                  mem.mem_we      <= wb_en;
                  mem.mem_addr    <= wb_en ? line_base(wb_addr) : line_base(req_addr);
                  state           <= wb_en ? WB_REQ : FILL_REQ;
               end
            end
            WB_REQ: begin
               if (mem.mem_stb) begin
                  mem.mem_addrstb <= 1'b0;
                  state           <= WB_GAP;
               end
            end
            WB_GAP: begin
               mem.mem_addrstb <= 1'b1;
               if (beat == LAST) begin
                  beat         <= '0;
                  wb_count     <= sat_inc(wb_count);
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= fill_base;
                  state        <= FILL_REQ;
               end else begin
                  beat         <= beat + 1'b1;
                  mem.mem_addr <= beat_addr(wb_base, beat + 1'b1);
                  state        <= WB_REQ;
               end
            end
            FILL_REQ: begin
               if (mem.mem_stb) begin
                  fill_data       <= mem.mem_rdata;
                  fill_idx        <= beat;
                  fill_we         <= 1'b1;
                  mem.mem_addrstb <= 1'b0;
                  state           <= FILL_GAP;
               end
            end
            FILL_GAP: begin
               if (beat == LAST) begin
                  fill_count <= sat_inc(fill_count);
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  beat            <= beat + 1'b1;
                  mem.mem_addrstb <= 1'b1;
                  mem.mem_addr    <= beat_addr(fill_base, beat + 1'b1);
                  state           <= FILL_REQ;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy            <= 1'b0;
               done            <= 1'b0;
               mem.mem_addrstb <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_line_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l2_line_fill_ctrl
// Self-checking bench for l2_line_fill_ctrl: directed vector table, random
// transactions against a line-level reference model, reset abort, and counter
// saturation on a second instance whose counters start near the top.
// ---------------------------------------------------------------------------
module tb_l2_line_fill_ctrl;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int LB = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic          reset, req, wb_en;
   logic [AW-1:0] req_addr, wb_addr;
   logic          busy, done, fill_we;
   logic [IW-1:0] wb_rd_idx, fill_idx;
   logic [DW-1:0] wb_rd_data, fill_data;
   logic [15:0]   wb_count, fill_count;
   logic [DW-1:0] victim [LB];

   l2_line_fill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   assign wb_rd_data = victim[wb_rd_idx];

   l2_line_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .wb_en(wb_en),
      .wb_addr(wb_addr), .busy(busy), .done(done), .wb_rd_idx(wb_rd_idx),
      .wb_rd_data(wb_rd_data), .fill_we(fill_we), .fill_idx(fill_idx),
      .fill_data(fill_data), .mem(mif.master), .wb_count(wb_count),
      .fill_count(fill_count)
   );

   // ---------------- saturation DUT ----------------
   logic          reset2, req2, busy2, done2, fill_we2;
   logic [IW-1:0] wb_rd_idx2, fill_idx2;
   logic [DW-1:0] fill_data2;
   logic [15:0]   wb_count2, fill_count2;

   l2_line_fill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) m2 ();

   // Zero-latency memory: ack in the strobe's first cycle.
   assign m2.mem_stb   = m2.mem_addrstb;
   assign m2.mem_rdata = {32'h0, m2.mem_addr};

   l2_line_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB),
                       .COUNT_INIT(16'hFFFB)) dut_sat (
      .clk(clk), .reset(reset2), .req(req2), .req_addr(32'h0000_0100), .wb_en(1'b1),
      .wb_addr(32'h0000_0200), .busy(busy2), .done(done2), .wb_rd_idx(wb_rd_idx2),
      .wb_rd_data(64'h1), .fill_we(fill_we2), .fill_idx(fill_idx2),
      .fill_data(fill_data2), .mem(m2.master), .wb_count(wb_count2),
      .fill_count(fill_count2)
   );

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory contents as seen by reads: a fixed function of the address.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hC0DE_F00D, ~a};
   endfunction

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [63:0] data;
   } op_t;

   typedef struct {
      logic [IW-1:0] idx;
      logic [63:0]   data;
   } fill_t;

   op_t   ops[$];
   fill_t fills[$];
   int    busy_cyc;

   // ---------------- memory responder (main DUT) ----------------
   bit resp_on  = 1'b1;
   bit spur     = 1'b0;
   int lat      = 0;
   int wait_cnt = 0;

   always @(negedge clk) begin
      if (!resp_on) begin
         wait_cnt = 0;
      end else begin
         mif.mem_stb = 1'b0;
         if (mif.mem_addrstb) begin
            if (wait_cnt >= lat) begin
               mif.mem_stb   = 1'b1;
               mif.mem_rdata = mem_word(mif.mem_addr);
               ops.push_back('{mif.mem_we, mif.mem_addr, mif.mem_wdata});
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            if (spur && $urandom_range(0, 1) == 1) begin
               mif.mem_stb   = 1'b1;
               mif.mem_rdata = {$urandom, $urandom};
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (fill_we) fills.push_back('{fill_idx, fill_data});
      if (busy) busy_cyc++;
   end

   // ---------------- reference model state ----------------
   int model_wb   = 0;
   int model_fill = 0;

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},      64'(busy), 64'h0);
      check({tag, "_done"},      64'(done), 64'h0);
      check({tag, "_fill_we"},   64'(fill_we), 64'h0);
      check({tag, "_addrstb"},   64'(mif.mem_addrstb), 64'h0);
      check({tag, "_mem_we"},    64'(mif.mem_we), 64'h0);
      check({tag, "_mem_addr"},  64'(mif.mem_addr), 64'h0);
      check({tag, "_mem_wdata"}, mif.mem_wdata, 64'h0);
      check({tag, "_fill_data"}, fill_data, 64'h0);
      check({tag, "_fill_idx"},  64'(fill_idx), 64'h0);
      check({tag, "_wb_rd_idx"}, 64'(wb_rd_idx), 64'h0);
      check({tag, "_wb_count"},  64'(wb_count), 64'h0);
      check({tag, "_fill_cnt"},  64'(fill_count), 64'h0);
   endtask

   // Run one miss transaction and compare it with the line-level model.
   task automatic do_txn(input logic [31:0] ra, input bit we, input logic [31:0] wa,
                         input int k, input bit sp, input bit hammer,
                         output int done_lat, output logic [31:0] first_addr);
      int          n;
      int          phases;
      logic [31:0] wbase, fbase;
      op_t         exp_ops[$];
      @(negedge clk);
      lat = k;
      spur = sp;
      ops.delete();
      fills.delete();
      busy_cyc = 0;
      for (int b = 0; b < LB; b++) victim[b] = {$urandom, $urandom};
      req_addr = ra;
      wb_addr  = wa;
      wb_en    = we;
      req      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      check("first_strobe", 64'({busy, mif.mem_addrstb}), 64'h3);
      if (!hammer) req = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done), 64'h1);
      done_lat   = n;
      first_addr = (ops.size() > 0) ? ops[0].addr : 32'hDEAD_BEEF;
      @(negedge clk);
      req = 1'b0;
      check("idle_after_done", 64'(busy), 64'h0);
      if (hammer) begin
         repeat (3) @(negedge clk);
         check("no_second_txn", 64'(busy), 64'h0);
      end

      // Model: aligned line bases, optional write-back, then a line read.
      wbase  = wa & ~32'h1F;
      fbase  = ra & ~32'h1F;
      phases = we ? 2 : 1;
      if (we) for (int b = 0; b < LB; b++) exp_ops.push_back('{1'b1, wbase + 32'(8 * b), victim[b]});
      for (int b = 0; b < LB; b++) exp_ops.push_back('{1'b0, fbase + 32'(8 * b), 64'h0});
      check("done_latency", 64'(n), 64'(phases * LB * (k + 2) + 1));
      check("busy_cycles",  64'(busy_cyc), 64'(phases * LB * (k + 2) + 1));
      check("op_count", 64'(ops.size()), 64'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size() && i < ops.size(); i++) begin
         check("op_we",   64'(ops[i].we), 64'(exp_ops[i].we));
         check("op_addr", 64'(ops[i].addr), 64'(exp_ops[i].addr));
         if (exp_ops[i].we) check("op_wdata", ops[i].data, exp_ops[i].data);
      end
      check("fill_count_beats", 64'(fills.size()), 64'(LB));
      for (int b = 0; b < LB && b < fills.size(); b++) begin
         check("fill_idx",  64'(fills[b].idx), 64'(b));
         check("fill_data", fills[b].data, mem_word(fbase + 32'(8 * b)));
      end
      if (we && model_wb < 32'hFFFF) model_wb++;
      if (model_fill < 32'hFFFF) model_fill++;
      check("wb_count",   64'(wb_count), 64'(model_wb));
      check("fill_count", 64'(fill_count), 64'(model_fill));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] ra;
      bit          we;
      logic [31:0] wa;
      int          k;
      bit          sp;
      bit          hammer;
      logic [31:0] exp_first_addr;
      int          exp_done_lat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          dl;
      int          n;
      int          fills_before;
      logic [31:0] fa;
      logic [31:0] exp_sat;

      vecs[0] = '{32'h0000_1234, 1'b0, 32'h0,         2, 1'b0, 1'b0, 32'h0000_1220, 17};
      vecs[1] = '{32'h0000_0040, 1'b1, 32'h0000_8010, 1, 1'b0, 1'b0, 32'h0000_8000, 25};
      vecs[2] = '{32'h0000_0005, 1'b0, 32'h0,         0, 1'b1, 1'b0, 32'h0000_0000, 9};
      vecs[3] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_001F, 0, 1'b1, 1'b0, 32'h0000_0000, 17};
      vecs[4] = '{32'h0000_2000, 1'b1, 32'h0000_3000, 3, 1'b0, 1'b1, 32'h0000_3000, 41};

      reset = 1'b1;
      reset2 = 1'b1;
      req = 1'b0;
      req2 = 1'b0;
      wb_en = 1'b0;
      req_addr = '0;
      wb_addr = '0;
      mif.mem_stb = 1'b0;
      mif.mem_rdata = '0;
      for (int b = 0; b < LB; b++) victim[b] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         do_txn(vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].k, vecs[i].sp,
                vecs[i].hammer, dl, fa);
         check("vec_first_addr", 64'(fa), 64'(vecs[i].exp_first_addr));
         check("vec_done_lat",   64'(dl), 64'(vecs[i].exp_done_lat));
      end

      // Random transactions.
      for (int i = 0; i < 25; i++) begin
         do_txn($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0, dl, fa);
      end

      // Reset during the third fill beat, with a same-cycle acknowledge.
      @(negedge clk);
      lat = 2;
      spur = 1'b0;
      fills.delete();
      req_addr = 32'h0000_7700;
      wb_en = 1'b0;
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!(fills.size() == 2 && mif.mem_addrstb) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_at_beat3", 64'(fills.size()), 64'h2);
      resp_on = 1'b0;
      mif.mem_stb = 1'b1;
      mif.mem_rdata = '1;
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("abort");
      reset = 1'b0;
      mif.mem_stb = 1'b0;
      fills_before = fills.size();
      repeat (2) begin
         @(negedge clk);
         mif.mem_stb = 1'b1;
         @(negedge clk);
         mif.mem_stb = 1'b0;
      end
      @(negedge clk);
      check("abort_no_fill_we", 64'(fills.size()), 64'(fills_before));
      check("abort_no_strobe", 64'(mif.mem_addrstb), 64'h0);
      check("abort_idle", 64'(busy), 64'h0);
      resp_on = 1'b1;
      model_wb = 0;
      model_fill = 0;
      do_txn(32'h0000_4444, 1'b1, 32'h0000_9990, 1, 1'b0, 1'b0, dl, fa);

      // Counter saturation on the second instance.
      @(negedge clk);
      check("sat_init_fill", 64'(fill_count2), 64'hFFFB);
      check("sat_init_wb",   64'(wb_count2), 64'hFFFB);
      reset2 = 1'b0;
      req2 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         n = 0;
         while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
         end
         exp_sat = (32'hFFFB + 32'(i) > 32'hFFFF) ? 32'hFFFF : 32'hFFFB + 32'(i);
         check("sat_fill", 64'(fill_count2), 64'(exp_sat));
         check("sat_wb",   64'(wb_count2), 64'(exp_sat));
         @(negedge clk);
      end
      req2 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
